uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity modes and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Unused upper bits of word must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [8:0] word, input int mode);
    return (^word) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, registered occupancy; zero-latency read of head.
// Push while full and pop while empty are ignored; full/empty depend on occupancy only.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_FULL);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointers are exactly AW bits wide, so wrap-around is the natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; first start bit appears two edges after the write into an idle block.
// data_ready is FIFO-not-full; frames run back-to-back while entries remain queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 1000,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BIT_PERIOD = (BAUD_RATE > 0) ? CLK_FREQ / BAUD_RATE : 0;
  localparam int CW         = $clog2(BIT_PERIOD * 2 + 1);
  localparam int IW         = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * BIT_PERIOD - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || PARITY < PAR_NONE || PARITY > PAR_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BAUD_RATE < 1 || BIT_PERIOD < 2) begin : g_param_err
    $error("uart_tx_fifo: illegal parameter combination");
  end

  uart_state_t           r_state;
  uart_state_t           w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic                  r_par;
  logic                  w_par_nxt;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  w_load;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_valid),
    .wdata   (data_in),
    .pop     (w_pop),
    .rdata   (w_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (fifo_count)
  );

  assign data_ready = !w_fifo_full;
  assign tx_busy    = (r_state != ST_IDLE);
  assign tx         = r_tx;
  assign w_pop      = w_load;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_tx_nxt    = 1'b1;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_load    = !w_fifo_empty;
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end
      end
      ST_PARITY: begin
        w_tx_nxt = r_par;
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == STOP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
          w_load      = !w_fifo_empty;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Loading from STOP skips IDLE entirely, giving gap-free back-to-back frames.
    if (w_load) begin
      w_state_nxt = ST_START;
      w_cnt_nxt   = '0;
      w_shift_nxt = w_head;
      w_par_nxt   = parity_bit(9'(w_head), PARITY);
    end
  end

  // tx is registered, so the line follows the state by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_par   <= w_par_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (no parity / even+2 stop / odd), BIT_PERIOD=8.
// A line monitor decodes frames; expected words are queued at write time and compared per frame.
module tb_uart_tx_fifo;

  typedef struct {
    int         dut;
    logic [7:0] w;
  } exp_t;

  typedef struct {
    int          dut;
    logic [15:0] f;
    int          gap;
    logic        gl;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] din    [3];
  logic       dv     [3];
  logic       rdy_w  [3];
  logic       tx_w   [3];
  logic       busy_w [3];
  logic [2:0] cnt_w  [3];

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   rd;
  int   n_tot;
  int   n_pass;
  int   n_fail;

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset_n(rst_n), .data_in(din[0]), .data_valid(dv[0]), .data_ready(rdy_w[0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_n(rst_n), .data_in(din[1]), .data_valid(dv[1]), .data_ready(rdy_w[1]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_count(cnt_w[1]));

  uart_tx_fifo #(.CLK_FREQ(8), .BAUD_RATE(1), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset_n(rst_n), .data_in(din[2]), .data_valid(dv[2]), .data_ready(rdy_w[2]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_count(cnt_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_of(input int d);
    return (d == 1) ? 1 : ((d == 2) ? 2 : 0);
  endfunction

  function automatic int ns_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int nb_of(input int d);
    return 9 + ((par_of(d) != 0) ? 1 : 0) + ns_of(d);
  endfunction

  // Bit i of the result is the line level during bit slot i (slot 0 = start).
  function automatic logic [15:0] exp_frame(input logic [7:0] w, input int par, input int ns);
    logic [15:0] v;
    int          k;
    v = '0;
    for (int i = 0; i < 8; i++) v[1+i] = w[i];
    k = 9;
    if (par != 0) begin
      v[9] = (^w) ^ (par == 2);
      k = 10;
    end
    for (int s = 0; s < ns; s++) v[k+s] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic wr(input int d, input logic [7:0] w);
    exp_t ex;
    din[d] = w;
    dv[d]  = 1'b1;
    ex.dut = d;
    ex.w   = w;
    exp_q.push_back(ex);
    @(negedge clk);
    dv[d] = 1'b0;
  endtask

  task automatic cmp_frames(input int n, input bit b2b, output logic [15:0] last_f);
    int   t;
    obs_t ob;
    exp_t ex;
    t = 0;
    last_f = '0;
    while (obs_q.size() < rd + n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("frame_arrived", 32'(obs_q.size() >= rd + n), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (rd < obs_q.size() && exp_q.size() > 0) begin
        ob = obs_q[rd];
        rd++;
        ex = exp_q.pop_front();
        chk($sformatf("frame_dut_%0h", ex.w), 32'(ob.dut), 32'(ex.dut));
        chk($sformatf("frame_bits_%0h", ex.w), 32'(ob.f), 32'(exp_frame(ex.w, par_of(ex.dut), ns_of(ex.dut))));
        chk($sformatf("bit_width_%0h", ex.w), 32'(ob.gl), 32'd0);
        if (b2b) chk($sformatf("b2b_gap_%0h", ex.w), 32'(ob.gap), 32'd0);
        last_f = ob.f;
      end
    end
  endtask

  // Line monitor: each bit slot must hold one level for all 8 clocks.
  bit          m_act [3];
  int          m_cyc [3];
  int          m_idle[3];
  int          m_gap [3];
  logic [15:0] m_f   [3];
  logic        m_gl  [3];
  obs_t        m_ob;
  int          m_b;

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_act[d] = 0; m_cyc[d] = 0; m_idle[d] = 0; m_gap[d] = 0; m_f[d] = '0; m_gl[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          m_act[d]  = 0;
          m_idle[d] = 0;
        end else if (!m_act[d]) begin
          if (tx_w[d] === 1'b0) begin
            m_act[d] = 1;
            m_cyc[d] = 1;
            m_f[d]   = '0;
            m_gl[d]  = 1'b0;
            m_gap[d] = m_idle[d];
          end else begin
            m_idle[d]++;
          end
        end else begin
          m_b = m_cyc[d] / 8;
          if (m_cyc[d] % 8 == 0) m_f[d][m_b] = tx_w[d];
          else if (tx_w[d] !== m_f[d][m_b]) m_gl[d] = 1'b1;
          m_cyc[d]++;
          if (m_cyc[d] == nb_of(d) * 8) begin
            m_ob.dut = d;
            m_ob.f   = m_f[d];
            m_ob.gap = m_gap[d];
            m_ob.gl  = m_gl[d];
            obs_q.push_back(m_ob);
            m_act[d]  = 0;
            m_idle[d] = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] lf;
    int          first_low;
    int          busy_n;
    int          t;
    logic        ok;
    int          sz;

    rd = 0; n_tot = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      din[d] = '0;
      dv[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_count", 32'(cnt_w[0]), 32'd0);
    chk("rst_ready", 32'(rdy_w[0]), 32'd1);

    // First write lands on the first edge after release; start bit two edges later.
    rst_n = 1'b1;
    wr(0, 8'hA5);
    chk("lat_count", 32'(cnt_w[0]), 32'd1);
    chk("lat_tx_idle", 32'(tx_w[0]), 32'd1);
    first_low = -1;
    busy_n = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (tx_w[0] === 1'b0 && first_low < 0) first_low = i;
      if (busy_w[0] === 1'b1) busy_n++;
    end
    chk("lat_start", 32'(first_low), 32'd2);
    chk("busy_len", 32'(busy_n), 32'd80);
    chk("busy_end", 32'(busy_w[0]), 32'd0);
    cmp_frames(1, 1'b0, lf);
    chk("a5_levels", 32'(lf), 32'h0000_034A);

    // Fill the FIFO while a frame is in flight; the fifth word must bounce.
    wr(0, 8'h3C);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      logic [7:0] w;
      exp_t ex;
      w = 8'(8'h11 * (k + 1));
      din[0] = w;
      dv[0]  = 1'b1;
      chk($sformatf("burst_ready_%0d", k), 32'(rdy_w[0]), (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) begin
        ex.dut = 0;
        ex.w   = w;
        exp_q.push_back(ex);
      end
      @(negedge clk);
    end
    chk("full_count", 32'(cnt_w[0]), 32'd4);
    chk("full_ready", 32'(rdy_w[0]), 32'd0);

    // Keep offering a word while full: the pop edge must not let it in.
    din[0] = 8'h66;
    t = 0;
    while (cnt_w[0] === 3'd4 && t < 150) begin
      @(negedge clk);
      t++;
    end
    dv[0] = 1'b0;
    chk("pop_while_full_count", 32'(cnt_w[0]), 32'd3);
    chk("pop_while_full_ready", 32'(rdy_w[0]), 32'd1);

    // Next pop is one full frame (80 clocks) after the one just seen.
    repeat (79) @(negedge clk);
    chk("pre_pop_count", 32'(cnt_w[0]), 32'd3);
    wr(0, 8'h77);
    chk("push_pop_count", 32'(cnt_w[0]), 32'd3);

    cmp_frames(1, 1'b0, lf);
    cmp_frames(5, 1'b1, lf);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) ok = 1'b0;
    end
    chk("idle_after_burst", 32'(ok), 32'd1);
    chk("no_extra_frame", 32'(obs_q.size() - rd), 32'd0);

    // Reset around clock 30 of a frame with two words still queued.
    wr(0, 8'h5A);
    wr(0, 8'h81);
    wr(0, 8'h42);
    repeat (28) @(negedge clk);
    chk("pre_rst_count", 32'(cnt_w[0]), 32'd2);
    chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_count", 32'(cnt_w[0]), 32'd0);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_ready", 32'(rdy_w[0]), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sz = obs_q.size();
    ok = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) ok = 1'b0;
    end
    chk("quiet_after_rst", 32'(ok), 32'd1);
    chk("no_frame_after_rst", 32'(obs_q.size() - sz), 32'd0);
    rd = obs_q.size();
    wr(0, 8'hE1);
    cmp_frames(1, 1'b0, lf);

    // Odd parity of 0x07 is 0.
    wr(2, 8'h07);
    cmp_frames(1, 1'b0, lf);
    chk("odd_parity_bit", 32'(lf[9]), 32'd0);
    chk("odd_stop_bit", 32'(lf[10]), 32'd1);

    // Even parity of 0x07 is 1; two 8-clock stop slots, then the next start immediately.
    wr(1, 8'h07);
    wr(1, 8'hC3);
    cmp_frames(1, 1'b0, lf);
    chk("even_parity_bit", 32'(lf[9]), 32'd1);
    chk("two_stop_bits", 32'(lf[11:10]), 32'd3);
    cmp_frames(1, 1'b1, lf);
    chk("c3_parity_bit", 32'(lf[9]), 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
